square_root_seq: RTL and testbench

//  Iterative, handshaked integer square root: floor(sqrt(x)) of an N-bit unsigned radicand,
//  U result bits per cycle (restoring digit-recurrence), with remainder and optional round-to-nearest.

---
 rtl/square_root_seq.sv | 177 +++++++++++++++++
 tb/tb_square_root_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_root_seq.sv
// Iterative restoring square root: floor(sqrt(x)) with remainder and optional
// round-to-nearest, resolving U root bits per cycle behind a valid/ready handshake.
module square_root_seq #(
    parameter int unsigned N = 16,
    parameter int unsigned U = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_x,
    input  logic             in_round,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N/2-1:0]   out_root,
    output logic [N/2:0]     out_rem,
    output logic             out_up,
    output logic             busy
);

    localparam int unsigned RW = N / 2;
    localparam int unsigned MW = RW + 1;
    localparam int unsigned TW = MW + 2;
    localparam int unsigned K  = N / (2 * U);
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [N-1:0]    x_sh;
    logic [MW-1:0]   rem_q;
    logic [RW-1:0]   root_q;
    logic [CW-1:0]   cnt_q;
    logic            round_q;

    logic [N-1:0]    x_d;
    logic [MW-1:0]   rem_d;
    logic [RW-1:0]   root_d;
    logic [CW-1:0]   cnt_d;
    logic            round_d;
    logic            out_valid_d;
    logic [RW-1:0]   out_root_d;
    logic [MW-1:0]   out_rem_d;
    logic            out_up_d;
    logic            in_ready_d;
    logic            busy_d;

    logic [N-1:0]    x_v;
    logic [MW-1:0]   rem_v;
    logic [RW-1:0]   root_v;
    logic [TW-1:0]   trial;
    logic            want_up;
    logic            root_full;

    // U restoring sub-steps per cycle, most significant radicand pair first
    always_comb begin
        x_v    = x_sh;
        rem_v  = rem_q;
        root_v = root_q;
        trial  = '0;
        for (int i = 0; i < int'(U); i++) begin
            // partial remainder is below 2^RW before each step, so its top bit is always 0
            trial = {1'b0, rem_v[MW-2:0], x_v[N-1 -: 2]} - {1'b0, root_v, 2'b01};
            if (!trial[TW-1]) begin
                rem_v  = MW'(trial);
                root_v = {root_v[RW-2:0], 1'b1};
            end else begin
                rem_v  = {rem_v[MW-3:0], x_v[N-1 -: 2]};
                root_v = {root_v[RW-2:0], 1'b0};
            end
            x_v = {x_v[N-3:0], 2'b00};
        end
    end

    assign want_up   = round_q && (rem_q > {1'b0, root_q});
    assign root_full = &root_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = BUSY;
            BUSY:    if (cnt_q == CW'(K - 1)) state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // next values for datapath and registered outputs
    always_comb begin
        x_d         = x_sh;
        rem_d       = rem_q;
        root_d      = root_q;
        cnt_d       = cnt_q;
        round_d     = round_q;
        out_valid_d = out_valid;
        out_root_d  = out_root;
        out_rem_d   = out_rem;
        out_up_d    = out_up;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    round_d = in_round;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                x_d    = x_v;
                rem_d  = rem_v;
                root_d = root_v;
                cnt_d  = cnt_q + CW'(1);
            end
            DONE: begin
                // rounding is resolved in its own cycle, off the iteration path
                if (!out_valid) begin
                    out_valid_d = 1'b1;
                    out_up_d    = want_up && !root_full;
                    out_root_d  = (want_up && !root_full) ? root_q + RW'(1) : root_q;
                    out_rem_d   = rem_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        in_ready_d = (state_nxt == IDLE);
        busy_d     = (state_nxt == BUSY);
    end

    // datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_sh      <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            cnt_q     <= '0;
            round_q   <= 1'b0;
            out_valid <= 1'b0;
            out_root  <= '0;
            out_rem   <= '0;
            out_up    <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            x_sh      <= x_d;
            rem_q     <= rem_d;
            root_q    <= root_d;
            cnt_q     <= cnt_d;
            round_q   <= round_d;
            out_valid <= out_valid_d;
            out_root  <= out_root_d;
            out_rem   <= out_rem_d;
            out_up    <= out_up_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_square_root_seq.sv
// Bench for square_root_seq: N=8/U=1 directed + exhaustive streaming, and
// N=16 at U=2 and U=1 in lockstep against a brute-force square-root model.
module tb_square_root_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       v8, rnd8, rdy8, ir8, ov8, up8, busy8;
    logic [7:0] x8;
    logic [3:0] root8;
    logic [4:0] rem8;

    logic        v16, rnd16, rdy16;
    logic [15:0] x16;
    logic        ir_a, ov_a, up_a, busy_a, ir_b, ov_b, up_b, busy_b;
    logic [7:0]  root_a, root_b;
    logic [8:0]  rem_a, rem_b;

    square_root_seq #(.N(8), .U(1)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .in_x(x8), .in_round(rnd8),
        .out_valid(ov8), .out_ready(rdy8), .out_root(root8), .out_rem(rem8), .out_up(up8),
        .busy(busy8)
    );

    square_root_seq #(.N(16), .U(2)) u16a (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir_a), .in_x(x16), .in_round(rnd16),
        .out_valid(ov_a), .out_ready(rdy16), .out_root(root_a), .out_rem(rem_a), .out_up(up_a),
        .busy(busy_a)
    );

    square_root_seq #(.N(16), .U(1)) u16b (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir_b), .in_x(x16), .in_round(rnd16),
        .out_valid(ov_b), .out_ready(rdy16), .out_root(root_b), .out_rem(rem_b), .out_up(up_b),
        .busy(busy_b)
    );

    typedef struct {
        int root;
        int rem;
        int up;
    } exp_t;

    exp_t sb8[$];
    exp_t sba[$];
    exp_t sbb[$];

    int vectors = 0;
    int miscompares = 0;

    function automatic exp_t model(input int x, input int n, input bit rnd);
        exp_t e;
        int   r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        e.rem  = x - r * r;
        e.up   = (rnd && e.rem > r && r != (1 << (n / 2)) - 1) ? 1 : 0;
        e.root = r + e.up;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input exp_t e);
        chk({tag, ".root"}, 32'(root8), e.root);
        chk({tag, ".rem"},  32'(rem8),  e.rem);
        chk({tag, ".up"},   32'(up8),   e.up);
    endtask

    task automatic accept8(input int x, input bit rnd);
        int n = 0;
        while (!ir8 && n < 50) begin tick(); n++; end
        chk("accept8.in_ready", 32'(ir8), 1);
        v8 = 1'b1; x8 = 8'(x); rnd8 = rnd;
        tick();
        v8 = 1'b0;
        sb8.push_back(model(x, 8, rnd));
    endtask

    task automatic wait_ov8(input string tag);
        int n = 0;
        while (!ov8 && n < 50) begin tick(); n++; end
        chk({tag, ".out_valid"}, 32'(ov8), 1);
    endtask

    task automatic collect8(input string tag);
        exp_t e;
        wait_ov8(tag);
        chk({tag, ".sb_nonempty"}, 32'(sb8.size() != 0), 1);
        if (sb8.size() != 0) begin
            e = sb8.pop_front();
            check8(tag, e);
        end
        rdy8 = 1'b1;
        tick();
        rdy8 = 1'b0;
        chk({tag, ".idle_ready"}, 32'(ir8), 1);
        chk({tag, ".valid_drop"}, 32'(ov8), 0);
    endtask

    task automatic run16(input int x, input bit rnd);
        exp_t e;
        int   n = 0;
        bit   ga = 0, gb = 0;
        while (!(ir_a && ir_b) && n < 60) begin tick(); n++; end
        chk("r16.in_ready", 32'(ir_a && ir_b), 1);
        v16 = 1'b1; x16 = 16'(x); rnd16 = rnd;
        tick();
        v16 = 1'b0;
        sba.push_back(model(x, 16, rnd));
        sbb.push_back(model(x, 16, rnd));
        n = 0;
        while (!(ga && gb) && n < 60) begin
            if (ov_a && !ga && sba.size() != 0) begin
                e = sba.pop_front();
                chk("u2.root", 32'(root_a), e.root);
                chk("u2.rem",  32'(rem_a),  e.rem);
                chk("u2.up",   32'(up_a),   e.up);
                ga = 1;
            end
            if (ov_b && !gb && sbb.size() != 0) begin
                e = sbb.pop_front();
                chk("u1.root", 32'(root_b), e.root);
                chk("u1.rem",  32'(rem_b),  e.rem);
                chk("u1.up",   32'(up_b),   e.up);
                gb = 1;
            end
            tick();
            n++;
        end
        chk("r16.both_done", 32'(ga && gb), 1);
    endtask

    initial begin
        exp_t e;
        int   xs[] = '{200, 210, 211, 255, 144, 255, 1, 2, 3, 99};
        bit   rs[] = '{0,   1,   1,   1,   0,   0,   1, 1, 1, 0};
        int   bx[] = '{0, 1, 2, 3, 4, 8, 15, 16, 32768, 40000, 65025, 65280, 65281, 65534, 65535};
        int   idx, got;
        bit   acc, hs;

        rst = 1'b1;
        v8 = 1'b0; x8 = '0; rnd8 = 1'b0; rdy8 = 1'b0;
        v16 = 1'b0; x16 = '0; rnd16 = 1'b0; rdy16 = 1'b1;
        repeat (3) tick();

        chk("rst.in_ready",  32'(ir8),   1);
        chk("rst.out_valid", 32'(ov8),   0);
        chk("rst.busy",      32'(busy8), 0);
        chk("rst.root",      32'(root8), 0);
        chk("rst.rem",       32'(rem8),  0);
        chk("rst.up",        32'(up8),   0);
        chk("rst.busy16",    32'(busy_a || busy_b), 0);

        // reset wins over a simultaneous offer
        v8 = 1'b1; x8 = 8'd77;
        tick();
        v8 = 1'b0; rst = 1'b0;
        chk("rst_vs_valid.in_ready", 32'(ir8), 1);
        tick();
        chk("rst_vs_valid.busy", 32'(busy8), 0);
        chk("rst_vs_valid.in_ready2", 32'(ir8), 1);

        // latency for x=0: out_valid exactly K+1 = 5 edges after accept
        accept8(0, 0);
        chk("lat.in_ready_drop", 32'(ir8), 0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("lat.pre%0d", c), 32'(ov8), 0);
            if (c == 1) chk("lat.busy", 32'(busy8), 1);
        end
        tick();
        chk("lat.at5", 32'(ov8), 1);
        collect8("x0");

        for (int i = 0; i < xs.size() - 1; i++) begin
            accept8(xs[i], rs[i]);
            collect8($sformatf("dir.x%0d.r%0d", xs[i], rs[i]));
        end

        // consumer stall: outputs hold, no new accept while in_valid stays high
        accept8(99, 1);
        wait_ov8("stall");
        e = model(99, 8, 1);
        v8 = 1'b1; x8 = 8'd17;
        for (int s = 0; s < 6; s++) begin
            check8($sformatf("stall%0d", s), e);
            chk("stall.valid", 32'(ov8), 1);
            chk("stall.in_ready", 32'(ir8), 0);
            tick();
        end
        v8 = 1'b0; rdy8 = 1'b1;
        tick();
        rdy8 = 1'b0;
        void'(sb8.pop_front());
        chk("stall.release_valid", 32'(ov8), 0);
        chk("stall.release_ready", 32'(ir8), 1);
        tick();
        chk("stall.no_accept", 32'(busy8), 0);

        // reset while busy at cnt=2
        accept8(100, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb8.delete();
        chk("midrst.valid", 32'(ov8), 0);
        chk("midrst.ready", 32'(ir8), 1);
        chk("midrst.busy",  32'(busy8), 0);
        accept8(49, 0);
        collect8("after_rst.x49");

        // exhaustive N=8, both modes, in_valid and out_ready held high
        rdy8 = 1'b1; v8 = 1'b1; x8 = 8'd0; rnd8 = 1'b0;
        idx = 0; got = 0;
        for (int cyc = 0; cyc < 8000 && got < 512; cyc++) begin
            acc = v8 && ir8;
            hs  = ov8 && rdy8;
            if (hs) begin
                chk("b2b.sb_nonempty", 32'(sb8.size() != 0), 1);
                if (sb8.size() != 0) begin
                    e = sb8.pop_front();
                    check8("b2b", e);
                end
                got++;
            end
            if (acc) begin
                sb8.push_back(model(int'(x8), 8, rnd8));
                idx++;
            end
            tick();
            if (acc) begin
                if (idx < 512) begin
                    x8 = 8'(idx % 256);
                    rnd8 = (idx >= 256);
                end else begin
                    v8 = 1'b0;
                end
            end
        end
        chk("b2b.count", 32'(got), 512);
        rdy8 = 1'b0;

        for (int i = 0; i < bx.size(); i++) begin
            run16(bx[i], 0);
            run16(bx[i], 1);
        end
        for (int i = 0; i < 150; i++) begin
            run16(int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
